// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  // Frame sequencer states; PAR is skipped entirely when parity is disabled.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per serial bit (integer divide, truncates).
  function automatic int bit_cycles(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handoff between the digit formatter and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: master holds pi_flag/pi_data until the slave pulses end_flag.
//
// Signals:
//   pi_data  - byte offered by the formatter
//   pi_flag  - byte-valid level, may stay high across frames
//   end_flag - one-cycle pulse in the final cycle of a frame
//   busy     - a frame is in flight; pi_flag/pi_data are ignored
interface uart_byte_tx_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       end_flag;
  logic       busy;

  modport master (
    output pi_data,
    output pi_flag,
    input  end_flag,
    input  busy
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output end_flag,
    output busy
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..N-1 while enabled and flags the last cycle.
// Latency: tick is combinational from the count register (same cycle).
// Backpressure: none; clr restarts the period, en freezes the count.
//
// Ports: clk, rstn, clr (restart at 0), en (count), tick (count == N-1 and en).
module uart_baud_gen #(
  parameter int N = 5208
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CW'(N - 1)) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == CW'(N - 1));

endmodule

// File: rtl/uart_byte_tx.sv
// UART transmitter: serialises each accepted byte as start/8 data/[parity]/stop(s).
// Latency: start bit appears on tx the cycle after accept; frame lasts F*N cycles.
// Backpressure: accepts only in IDLE; inputs ignored while busy, end_flag ends the frame.
//
// Ports:
//   clk, rstn - system clock (CLK Hz) and async active-low reset
//   up        - formatter handoff (pi_data, pi_flag in; end_flag, busy out)
//   tx        - registered serial line, idle high
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int UART_BPS  = 9600,
  parameter int CLK       = 50_000_000,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rstn,
  uart_byte_tx_if.slave up,
  output logic          tx
);
  localparam int   N         = bit_cycles(CLK, UART_BPS);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (N < 16) begin : g_bad_rate
    $error("uart_byte_tx: CLK/UART_BPS must be at least 16");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end

  uart_state_t state_q, state_d;
  logic        tx_q, tx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        accept;
  logic        tick;
  logic        busy;
  logic        end_flag;
  logic        par_bit;

  assign busy = (state_q != IDLE);

  uart_baud_gen #(
    .N (N)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

  // The shift register rotates rather than shifts, so after the eighth data
  // bit it holds the latched byte again and parity can be taken from it.
  assign par_bit = (PARITY == PARITY_ODD) ? ~^shreg_q : ^shreg_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // tx_d always carries the level for the *next* bit, so the registered tx
  // changes exactly on the cycle after each baud tick.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    accept     = 1'b0;
    end_flag   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (up.pi_flag) begin
          accept     = 1'b1;
          shreg_d    = up.pi_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          shreg_d = {shreg_q[0], shreg_q[7:1]};
          state_d = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              tx_d    = par_bit;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = {shreg_q[0], shreg_q[7:1]};
          end
        end
      end

      PAR: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            end_flag = 1'b1;
            tx_d     = 1'b1;
            state_d  = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx          = tx_q;
  assign up.busy     = busy;
  assign up.end_flag = end_flag;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: three instances cover no-parity/1-stop,
// even/2-stop and odd/1-stop at 20 clocks per bit.
module tb_uart_byte_tx;
  localparam int BPS    = 100_000;
  localparam int CLK_HZ = 2_000_000;
  localparam int N      = CLK_HZ / BPS;  // 20 cycles per bit

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic tx0, tx1, tx2;

  uart_byte_tx_if if0 ();
  uart_byte_tx_if if1 ();
  uart_byte_tx_if if2 ();

  uart_byte_tx #(.UART_BPS(BPS), .CLK(CLK_HZ), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .up(if0), .tx(tx0));
  uart_byte_tx #(.UART_BPS(BPS), .CLK(CLK_HZ), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .up(if1), .tx(tx1));
  uart_byte_tx #(.UART_BPS(BPS), .CLK(CLK_HZ), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rstn(rstn), .up(if2), .tx(tx2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic tx_of(input int d);
    case (d)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic end_of(input int d);
    case (d)
      0:       return if0.end_flag;
      1:       return if1.end_flag;
      default: return if2.end_flag;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  task automatic drive(input int d, input logic [7:0] data, input logic flag);
    case (d)
      0:       begin if0.pi_data = data; if0.pi_flag = flag; end
      1:       begin if1.pi_data = data; if1.pi_flag = flag; end
      default: begin if2.pi_data = data; if2.pi_flag = flag; end
    endcase
  endtask

  // Called #1 into cycle T0+1; returns #1 into cycle T0+F*N+1.
  // Checks every cycle of every bit against the hand-given frame.
  task automatic frame(input int d, input logic [7:0] b, input int f,
                       input bit has_par, input logic par, input bit noise,
                       input string tag);
    int         bad;
    int         ends;
    int         endpos;
    int         nbusy;
    logic       e;
    logic       mid;
    logic [7:0] dec;
    bad = 0; ends = 0; endpos = 0; nbusy = 0; dec = '0; mid = 1'b0;
    for (int k = 0; k < f; k++) begin
      if (k == 0)                  e = 1'b0;
      else if (k <= 8)             e = b[k-1];
      else if (k == 9 && has_par)  e = par;
      else                         e = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (tx_of(d) !== e) bad++;
        if (end_of(d) === 1'b1) begin ends++; endpos = k * N + c + 1; end
        if (busy_of(d) !== 1'b1) nbusy++;
        if (c == N / 2) mid = tx_of(d);
        if (noise) drive(d, 8'($urandom), 1'($urandom_range(1, 0)));
        @(posedge clk); #1;
      end
      if (k >= 1 && k <= 8) dec[k-1] = mid;
      else chk($sformatf("%s bit%0d", tag, k), 32'(mid), 32'(e));
    end
    chk($sformatf("%s byte", tag), 32'(dec), 32'(b));
    chk($sformatf("%s off-time cycles", tag), 32'(bad), 32'd0);
    chk($sformatf("%s end pulses", tag), 32'(ends), 32'd1);
    chk($sformatf("%s end position", tag), 32'(endpos), 32'(f * N));
    chk($sformatf("%s busy low in frame", tag), 32'(nbusy), 32'd0);
  endtask

  logic [7:0] t2_bytes [5] = '{8'h31, 8'h35, 8'h34, 8'h33, 8'h0A};

  initial begin
    #(10 * 40000);
    $display("FAIL watchdog: bench exceeded 40000 cycles");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int d = 0; d < 3; d++) drive(d, 8'h00, 1'b0);

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset tx d%0d", d), 32'(tx_of(d)), 32'd1);
      chk($sformatf("reset busy d%0d", d), 32'(busy_of(d)), 32'd0);
      chk($sformatf("reset end d%0d", d), 32'(end_of(d)), 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: single '1' frame, no parity
    chk("t1 idle tx", 32'(tx0), 32'd1);
    drive(0, 8'h31, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h31, 1'b0);
    frame(0, 8'h31, 10, 1'b0, 1'b0, 1'b0, "t1");
    chk("t1 busy after", 32'(busy_of(0)), 32'd0);
    chk("t1 tx after", 32'(tx0), 32'd1);

    // 2: back-to-back "1543\n" with pi_flag held
    repeat (2) @(posedge clk);
    #1;
    drive(0, t2_bytes[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      frame(0, t2_bytes[i], 10, 1'b0, 1'b0, 1'b0, $sformatf("t2 f%0d", i));
      chk($sformatf("t2 gap tx f%0d", i), 32'(tx0), 32'd1);
      chk($sformatf("t2 gap busy f%0d", i), 32'(busy_of(0)), 32'd0);
      if (i < 4) drive(0, t2_bytes[i+1], 1'b1);
      else       drive(0, 8'h00, 1'b0);
    end
    cnt = 0;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (busy_of(0) !== 1'b0 || tx0 !== 1'b1) cnt++;
    end
    chk("t2 idle after stream", 32'(cnt), 32'd0);

    // 3: even parity, two stop bits
    drive(1, 8'h31, 1'b1);
    @(posedge clk); #1;
    drive(1, 8'h31, 1'b0);
    frame(1, 8'h31, 12, 1'b1, 1'b1, 1'b0, "t3");

    // 4: parity corner bytes
    @(posedge clk); #1;
    drive(2, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(2, 8'h00, 1'b0);
    frame(2, 8'h00, 11, 1'b1, 1'b1, 1'b0, "t4 odd 00");
    @(posedge clk); #1;
    drive(2, 8'hFF, 1'b1);
    @(posedge clk); #1;
    drive(2, 8'hFF, 1'b0);
    frame(2, 8'hFF, 11, 1'b1, 1'b1, 1'b0, "t4 odd FF");
    @(posedge clk); #1;
    drive(1, 8'hFF, 1'b1);
    @(posedge clk); #1;
    drive(1, 8'hFF, 1'b0);
    frame(1, 8'hFF, 12, 1'b1, 1'b0, 1'b0, "t4 even FF");

    // 5: input noise during an A5 frame
    @(posedge clk); #1;
    drive(0, 8'hA5, 1'b1);
    @(posedge clk); #1;
    frame(0, 8'hA5, 10, 1'b0, 1'b0, 1'b1, "t5");
    drive(0, 8'h00, 1'b0);
    cnt = 0;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (busy_of(0) !== 1'b0 || tx0 !== 1'b1) cnt++;
    end
    chk("t5 idle after", 32'(cnt), 32'd0);

    // 6: reset during data bit 0 of 8'h5A, then a clean 8'h0A frame
    drive(0, 8'h5A, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h5A, 1'b0);
    repeat (N + N / 2) @(posedge clk);
    #1;
    chk("t6 tx before reset", 32'(tx0), 32'd0);
    rstn = 1'b0;
    #1;
    chk("t6 tx on reset", 32'(tx0), 32'd1);
    chk("t6 busy on reset", 32'(busy_of(0)), 32'd0);
    drive(0, 8'h0A, 1'b1);
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (end_of(0) !== 1'b0) cnt++;
      if (tx0 !== 1'b1) cnt++;
    end
    chk("t6 quiet during reset", 32'(cnt), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    drive(0, 8'h0A, 1'b0);
    frame(0, 8'h0A, 10, 1'b0, 1'b0, 1'b0, "t6");
    chk("t6 busy after", 32'(busy_of(0)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
